// File: rtl/game_pkg.sv
// Shared constants for the maze game flow: state codes, counter widths, default tick rate.
package game_pkg;
  localparam int STATE_W = 3;
  localparam int LIVES_W = 2;
  localparam int SCORE_W = 16;
  localparam int FRAME_W = 8;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_PLAY = 3'd1;
  localparam logic [STATE_W-1:0] ST_HIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_OVER = 3'd3;
  localparam logic [STATE_W-1:0] ST_WIN  = 3'd4;

  localparam int TICK_DIV_DEF = 100000;
endpackage

// File: rtl/pulse_divider.sv
// Free-running enable divider: tick is high in the cycle the count sits at DIV-1.
// Count holds while en is low; clr restarts it from zero.
module pulse_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en & ~clr & (cnt_q == LAST);
endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: title/play/hit/over/win phases, lives and score, and the move_tick pacing.
// Hit/coin act on the edge they are first sampled; the start button costs two synchronizer stages.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int LIVES      = 3,
  parameter int WIN_COINS  = 16,
  parameter int HIT_FRAMES = 60
) (
  input  logic               vga_clk,
  input  logic               arst_n,
  input  logic               btn_start,
  input  logic               frame_start,
  input  logic               hit,
  input  logic               coin_hit,
  output logic               move_tick,
  output logic               run,
  output logic               respawn,
  output logic               flash,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] coin_cnt,
  output logic [STATE_W-1:0] state
);
  logic               sync1_q, sync2_q, start_prev_q, hit_prev_q, coin_prev_q;
  logic [STATE_W-1:0] state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] coin_cnt_q, coin_cnt_d, coin_inc;
  logic [FRAME_W-1:0] frm_q, frm_d;
  logic               run_q, respawn_q, flash_q;
  logic               start_rise, hit_rise, coin_rise, enter_play;

  assign start_rise = sync2_q & ~start_prev_q;
  assign hit_rise   = hit & ~hit_prev_q;
  assign coin_rise  = coin_hit & ~coin_prev_q;
  assign coin_inc   = (coin_cnt_q == '1) ? coin_cnt_q : coin_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    coin_cnt_d = coin_cnt_q;
    frm_d      = frm_q;
    enter_play = 1'b0;
    case (state_q)
      ST_IDLE: if (start_rise) begin
        state_d    = ST_PLAY;
        lives_d    = LIVES_W'(LIVES);
        coin_cnt_d = '0;
        enter_play = 1'b1;
      end
      ST_PLAY: begin
        // A hit outranks a coin taken in the same cycle.
        if (hit_rise) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 1'b1;
            state_d = ST_HIT;
            frm_d   = '0;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
          end
        end else if (coin_rise) begin
          coin_cnt_d = coin_inc;
          if (coin_inc == SCORE_W'(WIN_COINS)) state_d = ST_WIN;
        end
      end
      ST_HIT: if (frame_start) begin
        frm_d = frm_q + 1'b1;
        if (frm_q + 1'b1 == FRAME_W'(HIT_FRAMES)) begin
          state_d    = ST_PLAY;
          enter_play = 1'b1;
        end
      end
      ST_OVER, ST_WIN: if (start_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      start_prev_q <= 1'b0;
      hit_prev_q   <= 1'b0;
      coin_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      lives_q      <= '0;
      coin_cnt_q   <= '0;
      frm_q        <= '0;
      run_q        <= 1'b0;
      respawn_q    <= 1'b0;
      flash_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_start;
      sync2_q      <= sync1_q;
      start_prev_q <= sync2_q;
      hit_prev_q   <= hit;
      coin_prev_q  <= coin_hit;
      state_q      <= state_d;
      lives_q      <= lives_d;
      coin_cnt_q   <= coin_cnt_d;
      frm_q        <= frm_d;
      run_q        <= (state_d == ST_PLAY);
      respawn_q    <= enter_play;
      flash_q      <= (state_d == ST_HIT) & frm_d[3];
    end
  end

  pulse_divider #(.DIV(TICK_DIV)) u_tick (
    .clk    (vga_clk),
    .arst_n (arst_n),
    .en     (run_q),
    .clr    (enter_play),
    .tick   (move_tick)
  );

  assign run      = run_q;
  assign respawn  = respawn_q;
  assign flash    = flash_q;
  assign lives    = lives_q;
  assign coin_cnt = coin_cnt_q;
  assign state    = state_q;
endmodule
